// File: rtl/div_unsigned_32x20_pkg.sv
// Shared types and widths for the 32x20 unsigned restoring divider.
package div_pkg;
  localparam int DIV_DW = 32;
  localparam int DIV_VW = 20;
  localparam int CNT_W  = $clog2(DIV_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/div_unsigned_32x20_if.sv
// Request/result bundle for div_unsigned_32x20.
interface div_unsigned_32x20_if import div_pkg::*; #(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
);
  // Handshake: start is sampled only while the divider is idle; dividend and
  // divisor are captured on that edge. busy is high while iterating. done is a
  // one-cycle pulse, never overlapping busy, and marks quotient, remainder and
  // div_by_zero valid; those results hold until the next completion.
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_unsigned_32x20_step.sv
// One restoring-division step: conditional subtract of the divisor from t.
module div_step #(
  parameter int VW = 20
) (
  input  logic [VW:0]   t,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);
  always_comb begin
    q_bit  = (t >= {1'b0, d});
    r_next = q_bit ? (t - {1'b0, d}) : t;
  end
endmodule

// File: rtl/div_unsigned_32x20.sv
// Multi-cycle unsigned divider, one quotient bit per clock, with a
// single-cycle fast path for a zero divisor.
module div_unsigned_32x20 import div_pkg::*; #(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic                 clk,
  input  logic                 rst,
  div_unsigned_32x20_if.slave  bus,
  output state_t               dbg_state
);
  state_t            state;
  logic [DW-1:0]     q_sh;
  logic [VW-1:0]     d_reg;
  logic [VW:0]       r_sh;
  logic [CNT_W-1:0]  cnt;
  logic [VW:0]       t;
  logic [VW:0]       r_next;
  logic              q_bit;
  logic              busy_r;
  logic              done_r;
  logic              dz_r;
  logic [DW-1:0]     quot_r;
  logic [VW-1:0]     rem_r;
  // The remainder stays below the divisor, so the top bit of r_sh is always 0.
  logic              unused_r_msb;

  assign t            = {r_sh[VW-1:0], q_sh[DW-1]};
  assign unused_r_msb = r_sh[VW];

  div_step #(.VW(VW)) u_step (
    .t      (t),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q_sh   <= '0;
      d_reg  <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              q_sh   <= bus.dividend;
              d_reg  <= bus.divisor;
              r_sh   <= '0;
              cnt    <= CNT_W'(DW - 1);
              busy_r <= 1'b1;
              state  <= RUN;
            end else begin
              quot_r <= '1;
              rem_r  <= bus.dividend[VW-1:0];
              dz_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= FIN;
            end
          end
        end
        RUN: begin
          r_sh <= r_next;
          q_sh <= {q_sh[DW-2:0], q_bit};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            quot_r <= {q_sh[DW-2:0], q_bit};
            rem_r  <= r_next[VW-1:0];
            dz_r   <= 1'b0;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
  assign dbg_state       = state;
endmodule

// File: doc/div_unsigned_32x20.md
# div_unsigned_32x20

Multi-cycle unsigned restoring divider that is the inverse of the unsigned 32x20 multiplier in the Calc_G datapath. It divides a 32-bit dividend by a 20-bit divisor, one quotient bit per clock. It returns a full 32-bit quotient and a 20-bit remainder through a start/busy/done handshake. It recovers a scale or parameter from a product and normalises accumulated terms before the theta stage.

## Interface
Parameters:
- DW, 32: dividend and quotient width.
- VW, 20: divisor and remainder width. VW ≤ DW is required.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- start, in, 1: request. Sampled only in IDLE.
- dividend, in, DW: numerator. Captured on the accept edge.
- divisor, in, VW: denominator. Captured on the accept edge.
- busy, out, 1: high while a division is in progress.
- done, out, 1: one-cycle pulse when the quotient and remainder are valid.
- quotient, out, DW: result. Held until the next completion.
- remainder, out, VW: result. Held until the next completion.
- div_by_zero, out, 1: set with done when the divisor is 0. Held until the next completion.

## Operation
- The FSM has three states: IDLE, RUN and FIN.
- IDLE → RUN: start=1 and divisor≠0.
  - Capture the dividend into a shift register q_sh and the divisor into d_reg.
  - Clear the partial remainder r_sh (VW+1 bits) and load the bit counter cnt with DW-1.
- IDLE → FIN: start=1 and divisor=0. This is the zero fast path. Latch quotient={DW{1}}, remainder=dividend[VW-1:0] and div_by_zero=1.
- RUN, each cycle:
  - Form t = {r_sh[VW-1:0], q_sh[DW-1]}.
  - If t ≥ d_reg: r_sh ← t − d_reg and shift 1 into the q_sh LSB.
  - Otherwise: r_sh ← t and shift 0 into the q_sh LSB.
  - q_sh shifts left by 1. cnt decrements.
- RUN → FIN: on the cycle cnt=0, after that cycle's step. Latch quotient ← final q_sh, remainder ← final r_sh[VW-1:0] and div_by_zero ← 0.
- FIN → IDLE: unconditional after one cycle.
- Arithmetic rules:
  - The compare and subtract use VW+1 bits, so there is no overflow.
  - The remainder is always < divisor.
  - quotient·divisor + remainder = dividend exactly.
- start is ignored in RUN and FIN. There is no queueing, and the request is lost.
- The dividend and divisor inputs are don't-care outside the accept edge.

## Timing
- Reset values (asynchronous, effective immediately):
  - State is IDLE.
  - busy, done, div_by_zero, quotient and remainder are all 0.
  - The internal registers are 0.
- Accept edge E0 (IDLE with start=1): busy is high from E0.
- Normal latency:
  - RUN occupies edges E1..E32 (DW edges).
  - The results are registered at E32. State is FIN after E32, with done=1 and busy=0.
  - Back in IDLE after E33. A new start is accepted at E34 at the earliest.
  - Throughput is one division per DW+2 cycles.
- Zero divisor:
  - FIN after E0, with done=1 and div_by_zero=1. busy stays 0.
  - IDLE after E1.
- done is exactly one cycle long and is never asserted together with busy.
- The result outputs change only on the edge that enters FIN.
- Reset asserted mid-RUN aborts the operation. No done is produced, and the outputs return to 0.
- start held high continuously starts a new division each time IDLE is re-entered.

## Structure
- Package div_pkg holds:
  - A state enum: IDLE=2'd0, RUN=2'd1, FIN=2'd2.
  - A localparam for the counter width, $clog2(DW).
- The single-bit compare/subtract step goes in one natural combinational sub-module, div_step. Its inputs are t and d_reg, and its outputs are the next remainder and the quotient bit.
- The FSM, the shift registers and the output latches stay in the top module.

## Test plan
- 100 / 7 → done at E32, quotient=14, remainder=2, div_by_zero=0. busy is high for 32 cycles.
- 32'hFFFF_FFFF / 20'hF_FFFF → quotient=32'h0000_1000, remainder=20'h00FFF.
- 5 / 9 → quotient=0, remainder=5. 20'h12345 / 1 → quotient=32'h12345, remainder=0.
- 1234 / 0 → done one cycle after accept, quotient=32'hFFFF_FFFF, remainder=1234, div_by_zero=1. busy stays 0.
- start pulsed with 50/3 at cycle 10 of a 100/7 run → ignored. The result is still 14 r 2, and only one done pulse is produced.
- rst asserted at cycle 15 of a run → busy=0 and outputs zero immediately, no done. A following 81/9 → 9 r 0.
- Random sweep of 10k operands against the reference model. Check q·d+r=dividend and r<d.
